// File: rtl/regression_pass_sequencer.sv
// regression_pass_sequencer: two-pass sample-memory sequencer (coefficient pass, then error pass)
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   start_i, abort_i    run request (taken only in IDLE) and synchronous abort
//   mem_valid_i         sample at mem_addr_o is presented this cycle
//   coef_done_i         coefficient unit finished its divide (level or pulse)
//   mem_rd_o, mem_addr_o  sample-memory read request and address
//   cc_clr_o, en_cc_o   coefficient accumulator clear / accumulate
//   err_clr_o, en_err_o error accumulator clear / accumulate
//   busy_o, done_o      run in progress / one-cycle completion pulse
module regression_pass_sequencer #(
  parameter int N_SAMPLES = 150,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              mem_valid_i,
  input  logic              coef_done_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              cc_clr_o,
  output logic              en_cc_o,
  output logic              err_clr_o,
  output logic              en_err_o,
  output logic              busy_o,
  output logic              done_o
);
  typedef enum logic [2:0] {IDLE, CC_CLR, CC_RUN, CC_WAIT, ERR_CLR, ERR_RUN, FIN} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_SAMPLES - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE:    state_d = start_i ? CC_CLR : IDLE;
      CC_CLR:  begin state_d = CC_RUN; addr_d = '0; end
      CC_WAIT: state_d = coef_done_i ? ERR_CLR : CC_WAIT;
      ERR_CLR: begin state_d = ERR_RUN; addr_d = '0; end
      CC_RUN, ERR_RUN:
        // a stalled cycle holds both address and state; the last accepted sample rewinds the address
        if (mem_valid_i) begin
          addr_d  = (addr_q == LAST) ? '0 : addr_q + 1'b1;
          state_d = (addr_q != LAST) ? state_q : (state_q == CC_RUN) ? CC_WAIT : FIN;
        end
      default: state_d = IDLE;
    endcase
    // abort outranks everything but rst; in IDLE it also suppresses a simultaneous start
    if (abort_i) begin
      state_d = IDLE;
      addr_d  = '0;
    end
  end
  assign mem_addr_o = addr_q;
  assign mem_rd_o   = (state_q == CC_RUN) || (state_q == ERR_RUN);
  assign cc_clr_o   = state_q == CC_CLR;
  assign err_clr_o  = state_q == ERR_CLR;
  assign en_cc_o    = (state_q == CC_RUN) && mem_valid_i;
  assign en_err_o   = (state_q == ERR_RUN) && mem_valid_i;
  assign busy_o     = state_q != IDLE;
  assign done_o     = state_q == FIN;
endmodule
